// File: rtl/arbitro_rr2_mux_pkg.sv
// Shared types for the two-source round-robin arbiter that owns the 2:1 mux select.
package arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic SEL_I0 = 1'b0;
    localparam logic SEL_I1 = 1'b1;
endpackage

// File: rtl/arbitro_rr2_mux_if.sv
// Request/grant bundle between the two sources and the arbiter.
interface arbitro_rr2_mux_if #(parameter int CNT_W = 2);
    logic             req0;
    logic             req1;
    logic             S;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic [CNT_W-1:0] burst_cnt;

    modport master (output req0, req1, input S, gnt0, gnt1, busy, burst_cnt);
    modport slave  (input req0, req1, output S, gnt0, gnt1, busy, burst_cnt);
endinterface

// File: rtl/arbitro_rr2_mux_contador_rafaga.sv
// Burst length counter: clear, increment, and terminal-count flag at MAX_BURST-1.
module contador_rafaga #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(MAX_BURST - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + CNT_W'(1);
    end

    // The FSM releases at TERM, so the counter never needs to wrap.
    assign tc = (cnt == TERM);
endmodule

// File: rtl/mux2x1.sv
// Plain 2:1 data mux steered by the arbiter's S output.
module mux2x1 #(parameter int W = 8) (
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic         S,
    output logic [W-1:0] Y
);
    assign Y = S ? i1 : i0;
endmodule

// File: rtl/arbitro_rr2_mux.sv
// Round-robin arbiter with bounded bursts; grants, select and last-owner are registered.
module arbitro_rr2_mux
    import arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST)
) (
    input  logic              clk,
    input  logic              rst_n,
    arbitro_rr2_mux_if.slave  bus
);
    arb_state_t       state, state_nxt;
    logic             last;
    logic             s_q, gnt0_q, gnt1_q;
    logic             clr, inc, tc;
    logic [CNT_W-1:0] cnt;

    contador_rafaga #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc),
        .cnt   (cnt),
        .tc    (tc)
    );

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        inc       = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
                // Tie goes to the source that did not own the path last.
                if (bus.req0 && (!bus.req1 || last)) state_nxt = OWN0;
                else if (bus.req1)                   state_nxt = OWN1;
            end
            OWN0: begin
                if (!bus.req0 || tc) begin
                    clr = 1'b1;
                    if (bus.req1)      state_nxt = OWN1;
                    else if (bus.req0) state_nxt = OWN0;
                    else               state_nxt = IDLE;
                end else begin
                    inc = 1'b1;
                end
            end
            OWN1: begin
                if (!bus.req1 || tc) begin
                    clr = 1'b1;
                    if (bus.req0)      state_nxt = OWN0;
                    else if (bus.req1) state_nxt = OWN1;
                    else               state_nxt = IDLE;
                end else begin
                    inc = 1'b1;
                end
            end
            default: begin
                clr       = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last   <= 1'b1;
            s_q    <= SEL_I0;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            gnt0_q <= (state_nxt == OWN0);
            gnt1_q <= (state_nxt == OWN1);
            // S holds through IDLE so the mux output does not move between bursts.
            if (state_nxt == OWN0) begin
                last <= 1'b0;
                s_q  <= SEL_I0;
            end else if (state_nxt == OWN1) begin
                last <= 1'b1;
                s_q  <= SEL_I1;
            end
        end
    end

    assign bus.S         = s_q;
    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.busy      = gnt0_q | gnt1_q;
    assign bus.burst_cnt = cnt;
endmodule

// File: doc/arbitro_rr2_mux.md
# arbitro_rr2_mux

Two-requester round-robin arbiter with bounded burst length, placed directly upstream of the 2:1 mux. It owns the mux select line. Two sources compete for the shared path. The arbiter grants one source at a time and drives `S` so the mux output `Y` carries the granted source's `i0`/`i1` data. The burst limit keeps one source from holding the path indefinitely.

## Interface
- `MAX_BURST`, default 4: maximum consecutive granted cycles per source while the other source is requesting. Legal range is 2..256.
- `CNT_W`, default `$clog2(MAX_BURST)`: width of the burst counter. Derived; never overridden.

- `clk`  in  1  system clock. All state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req0`  in  1  source 0 requests the path (level; mux input `i0`).
- `req1`  in  1  source 1 requests the path (level; mux input `i1`).
- `S`  out  1  mux select: 0 = `i0`, 1 = `i1`. Registered.
- `gnt0`  out  1  source 0 owns the path this cycle. Registered.
- `gnt1`  out  1  source 1 owns the path this cycle. Registered.
- `busy`  out  1  `gnt0 | gnt1`.
- `burst_cnt`  out  CNT_W  granted cycles elapsed in the current burst, starting at 0.

## Operation
- States:
  - `IDLE`: no grant.
  - `OWN0`: `gnt0`=1, `S`=0.
  - `OWN1`: `gnt1`=1, `S`=1.
- `last` register holds the most recently granted source. Reset value is 1, so the first tie goes to source 0.
- From `IDLE`:
  - only `req0` → `OWN0`.
  - only `req1` → `OWN1`.
  - both → the source ≠ `last`.
  - neither → stay in `IDLE`.
- In `OWNx`, release occurs when `reqx`=0 OR `burst_cnt`==MAX_BURST-1.
- On release:
  - other source requesting → switch directly to the other `OWN` state, with no idle bubble.
  - otherwise, `reqx` still 1 (burst exhausted, no contention) → re-grant the same source with `burst_cnt` cleared to 0.
  - otherwise → `IDLE`.
- In `OWNx` without release, `burst_cnt` increments by 1. It never wraps: release fires at MAX_BURST-1.
- Entering any `OWN` state loads `burst_cnt`=0 and `last`=x.
- `S` in `IDLE` holds its last value, so the mux does not glitch between bursts.
- `gnt0` and `gnt1` are never both 1. `gnt0`=1 implies `S`=0, and `gnt1`=1 implies `S`=1.
- Reset values: state `IDLE`, `S`=0, `gnt0`=0, `gnt1`=0, `busy`=0, `burst_cnt`=0, `last`=1.
- `rst_n` low mid-burst forces all outputs to reset values immediately, with no clock needed. The first grant after release uses the reset `last` value.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled high at edge k gives the grant visible after edge k.
- Grant drop is also 1 cycle: `reqx` sampled low at edge k gives `gntx`=0 after edge k.
- Under continuous contention each source holds exactly MAX_BURST cycles, then ownership alternates every MAX_BURST cycles with zero dead cycles.
- Source changes during a grant are only sampled at the clock edge. Outputs never depend combinationally on `req0`/`req1`.
- `rst_n` deassertion is synchronized externally. The first active edge after deassertion evaluates requests normally.

## Structure
- Shared package `arb_pkg`:
  - state enum `arb_state_t` {IDLE, OWN0, OWN1}.
  - constant `SEL_I0`=1'b0, `SEL_I1`=1'b1.
- The burst counter (load-zero / increment / terminal-count flag) is a natural sub-module `contador_rafaga`, parameterised by `MAX_BURST`.
- FSM, `last` register and output registers live in the top module.
- The bench instantiates this block feeding `mux2x1` (`S`→`S`) and checks `Y` against the granted input.

## Test plan
- Reset: `rst_n`=0 with `req0`=`req1`=1 → `S`=0, `gnt0`=`gnt1`=0, `burst_cnt`=0. After release, the first grant goes to source 0.
- Single requester: `req0`=1 for 3 cycles, then 0, with MAX_BURST=4 → `gnt0` high 3 cycles starting 1 cycle late, then `IDLE`. `S` stays 0 throughout.
- Contention, MAX_BURST=4, both requests held high 16 cycles → `gnt0` 4 cycles, `gnt1` 4, `gnt0` 4, `gnt1` 4. `burst_cnt` runs 0..3 each burst. No idle cycle between bursts.
- Burst exhausted without contention: `req1` alone held high 10 cycles → `gnt1` continuous. `burst_cnt` runs 0,1,2,3,0,1,2,3,0,1. `S`=1 throughout.
- Early release plus handoff: both requesting, `OWN0` at `burst_cnt`=1, then `req0` drops → next cycle `gnt1`=1, `S`=1, `burst_cnt`=0. `mux2x1` `Y` equals `i1` from that cycle.
- Async reset mid-burst: `OWN1` at `burst_cnt`=2, `rst_n` pulled low between edges → outputs go to reset values before the next edge. With both requests still high after release, the grant goes to source 0.
